// File: rtl/pc_stack_seq.sv
// Program-counter sequencer for the 9-bit-instruction accumulator core.
// It drives the InstROM fetch address and sits between Ctrl/ALU and InstROM.
// The run-state FSM has three states: IDLE, RUN and HALT.
// Features: stall, relative branch, absolute jump, and call/return through
// a hardware return stack. It also keeps saturating cycle and instruction
// counters.
//
// Ports:
//   CLK            clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          synchronous init; loads start_address, enters RUN
//   start_address  PC load value on start
//   halt_req       halt instruction decoded
//   stall          hold PC this cycle, ignore control inputs
//   branch/taken   relative branch and its condition
//   offset         signed relative branch offset (TW bits)
//   jump_abs       unconditional absolute jump to abs_target
//   call/ret       push return address and jump / pop return address
//   abs_target     absolute jump/call target
//   PC             current fetch address (registered)
//   done           high while in HALT
//   sp             return-stack occupancy
//   stack_ovf      sticky: call attempted with stack full
//   stack_unf      sticky: ret attempted with stack empty
//   cycle_ct       saturating count of RUN cycles
//   inst_ct        saturating count of retired instructions
module pc_stack_seq #(
    parameter int unsigned PW       = 10,
    parameter int unsigned TW       = 8,
    parameter int unsigned SD       = 4,
    parameter int unsigned CW       = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                       CLK,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [PW-1:0]              start_address,
    input  logic                       halt_req,
    input  logic                       stall,
    input  logic                       branch,
    input  logic                       taken,
    input  logic [TW-1:0]              offset,
    input  logic                       jump_abs,
    input  logic                       call,
    input  logic                       ret,
    input  logic [PW-1:0]              abs_target,
    output logic [PW-1:0]              PC,
    output logic                       done,
    output logic [$clog2(SD+1)-1:0]    sp,
    output logic                       stack_ovf,
    output logic                       stack_unf,
    output logic [CW-1:0]              cycle_ct,
    output logic [CW-1:0]              inst_ct
);

    localparam int unsigned SPW = $clog2(SD + 1);
    // Stack index width; at least 1 bit so that SD == 1 still has a legal index.
    localparam int unsigned AW  = (SD > 1) ? $clog2(SD) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    logic [1:0]     state;
    logic [1:0]     state_d;
    logic [PW-1:0]  pc_d;
    logic [SPW-1:0] sp_d;
    logic           ovf_d;
    logic           unf_d;
    logic           done_d;
    logic [CW-1:0]  cyc_d;
    logic [CW-1:0]  inst_d;
    logic           retire;

    logic           push_en;
    logic [AW-1:0]  push_idx;
    logic [PW-1:0]  push_data;
    logic [PW-1:0]  pop_data;
    logic [PW-1:0]  off_ext;
    logic [PW-1:0]  pc_inc;

    // Return-stack storage; contents are don't-care after reset, so no reset.
    logic [PW-1:0]  stack_mem [2**AW];

    assign off_ext  = PW'($signed(offset));
    assign pc_inc   = PC + PW'(1);
    assign pop_data = stack_mem[AW'(sp - SPW'(1))];

    // Next-state, datapath and stack-write decode.
    always_comb begin
        state_d   = state;
        pc_d      = PC;
        sp_d      = sp;
        ovf_d     = stack_ovf;
        unf_d     = stack_unf;
        cyc_d     = cycle_ct;
        inst_d    = inst_ct;
        retire    = 1'b0;
        push_en   = 1'b0;
        push_idx  = AW'(sp);
        push_data = pc_inc;

        if (start) begin
            state_d = ST_RUN;
            pc_d    = start_address;
            sp_d    = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            cyc_d   = '0;
            inst_d  = '0;
        end else if (state == ST_RUN) begin
            // Every RUN cycle counts, including stalls and the halting cycle.
            if (cycle_ct != '1) begin
                cyc_d = cycle_ct + CW'(1);
            end

            if (halt_req) begin
                state_d = ST_HALT;
            end else if (!stall) begin
                if (ret) begin
                    // A ret on an empty stack is a fault; PC is held.
                    if (sp == '0) begin
                        unf_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d   = pop_data;
                        sp_d   = sp - SPW'(1);
                        retire = 1'b1;
                    end
                end else if (call) begin
                    // A call on a full stack is a fault; PC and stack are held.
                    if (sp == SPW'(SD)) begin
                        ovf_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp + SPW'(1);
                        pc_d    = abs_target;
                        retire  = 1'b1;
                    end
                end else if (jump_abs) begin
                    pc_d   = abs_target;
                    retire = 1'b1;
                end else if (branch && taken) begin
                    pc_d   = PC + off_ext;
                    retire = 1'b1;
                end else begin
                    pc_d   = pc_inc;
                    retire = 1'b1;
                end
            end

            if (retire && (inst_ct != '1)) begin
                inst_d = inst_ct + CW'(1);
            end
        end

        done_d = (state_d == ST_HALT);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            PC        <= PW'(RESET_PC);
            sp        <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            cycle_ct  <= '0;
            inst_ct   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            PC        <= pc_d;
            sp        <= sp_d;
            stack_ovf <= ovf_d;
            stack_unf <= unf_d;
            cycle_ct  <= cyc_d;
            inst_ct   <= inst_d;
            done      <= done_d;
        end
    end

    // Return-stack write port.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_mem[push_idx] <= push_data;
        end
    end

endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed testbench for pc_stack_seq.
// The main instance uses the default parameters (PW=10, TW=8, SD=4, CW=16).
// A second instance with CW=4 shares every input and is used for the
// saturation check.
module tb_pc_stack_seq;

    logic        CLK;
    logic        reset_n;
    logic        start;
    logic [9:0]  start_address;
    logic        halt_req;
    logic        stall;
    logic        branch;
    logic        taken;
    logic [7:0]  offset;
    logic        jump_abs;
    logic        call;
    logic        ret;
    logic [9:0]  abs_target;

    logic [9:0]  PC;
    logic        done;
    logic [2:0]  sp;
    logic        stack_ovf;
    logic        stack_unf;
    logic [15:0] cycle_ct;
    logic [15:0] inst_ct;

    logic [9:0]  pc4;
    logic        done4;
    logic [2:0]  sp4;
    logic        ovf4;
    logic        unf4;
    logic [3:0]  cycle_ct4;
    logic [3:0]  inst_ct4;

    int total = 0;
    int bad   = 0;

    pc_stack_seq dut (
        .CLK(CLK), .reset_n(reset_n), .start(start), .start_address(start_address),
        .halt_req(halt_req), .stall(stall), .branch(branch), .taken(taken),
        .offset(offset), .jump_abs(jump_abs), .call(call), .ret(ret),
        .abs_target(abs_target), .PC(PC), .done(done), .sp(sp),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf), .cycle_ct(cycle_ct),
        .inst_ct(inst_ct)
    );

    pc_stack_seq #(.CW(4)) dut4 (
        .CLK(CLK), .reset_n(reset_n), .start(start), .start_address(start_address),
        .halt_req(halt_req), .stall(stall), .branch(branch), .taken(taken),
        .offset(offset), .jump_abs(jump_abs), .call(call), .ret(ret),
        .abs_target(abs_target), .PC(pc4), .done(done4), .sp(sp4),
        .stack_ovf(ovf4), .stack_unf(unf4), .cycle_ct(cycle_ct4),
        .inst_ct(inst_ct4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; start_address = '0; halt_req = 0; stall = 0; branch = 0;
        taken = 0; offset = '0; jump_abs = 0; call = 0; ret = 0; abs_target = '0;
    endtask

    task automatic do_start(input logic [9:0] addr);
        start = 1; start_address = addr;
        tick();
        start = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        tick(); tick();
        total++; if (PC !== 10'h000) begin $display("FAIL reset_pc: got %h want %h", PC, 10'h000); bad++; end
        total++; if (done !== 1'b0 || sp !== 3'd0) begin $display("FAIL reset_done_sp: got %b/%0d want 0/0", done, sp); bad++; end
        total++; if (stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin $display("FAIL reset_flags: got %b%b want 00", stack_ovf, stack_unf); bad++; end
        total++; if (cycle_ct !== 16'd0 || inst_ct !== 16'd0) begin $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_ct, inst_ct); bad++; end
        reset_n = 1;
        tick(); tick();
        // IDLE holds everything.
        total++; if (PC !== 10'h000 || cycle_ct !== 16'd0) begin $display("FAIL idle_hold: got %h/%0d want 000/0", PC, cycle_ct); bad++; end
    endtask

    task automatic test_start_run();
        do_start(10'h010);
        total++; if (PC !== 10'h010) begin $display("FAIL start_pc: got %h want %h", PC, 10'h010); bad++; end
        total++; if (cycle_ct !== 16'd0 || inst_ct !== 16'd0 || done !== 1'b0) begin $display("FAIL start_state: got %0d/%0d/%b want 0/0/0", cycle_ct, inst_ct, done); bad++; end
        tick(); tick(); tick();
        total++; if (PC !== 10'h013) begin $display("FAIL run3_pc: got %h want %h", PC, 10'h013); bad++; end
        total++; if (cycle_ct !== 16'd3 || inst_ct !== 16'd3) begin $display("FAIL run3_counters: got %0d/%0d want 3/3", cycle_ct, inst_ct); bad++; end
    endtask

    task automatic test_branch();
        do_start(10'h005);
        branch = 1; taken = 1; offset = 8'hFE;
        tick();
        total++; if (PC !== 10'h003) begin $display("FAIL branch_back: got %h want %h", PC, 10'h003); bad++; end
        do_start(10'h005);
        branch = 1; taken = 0; offset = 8'hFE;
        tick();
        total++; if (PC !== 10'h006) begin $display("FAIL branch_not_taken: got %h want %h", PC, 10'h006); bad++; end
        do_start(10'h000);
        branch = 1; taken = 1; offset = 8'hFF;
        tick();
        total++; if (PC !== 10'h3FF) begin $display("FAIL branch_wrap_down: got %h want %h", PC, 10'h3FF); bad++; end
        branch = 0; taken = 0;
        tick();
        total++; if (PC !== 10'h000) begin $display("FAIL inc_wrap: got %h want %h", PC, 10'h000); bad++; end
        do_start(10'h3FE);
        branch = 1; taken = 1; offset = 8'h05;
        tick();
        total++; if (PC !== 10'h003) begin $display("FAIL branch_wrap_up: got %h want %h", PC, 10'h003); bad++; end
        offset = 8'h80;
        tick();
        total++; if (PC !== 10'h383) begin $display("FAIL branch_min_offset: got %h want %h", PC, 10'h383); bad++; end
        total++; if (inst_ct !== 16'd2) begin $display("FAIL branch_inst_ct: got %0d want 2", inst_ct); bad++; end
        clear_inputs();
    endtask

    task automatic test_call_ret();
        logic [9:0] tgt [4];
        logic [9:0] rta [4];
        tgt[0] = 10'h040; tgt[1] = 10'h060; tgt[2] = 10'h080; tgt[3] = 10'h100;
        rta[0] = 10'h081; rta[1] = 10'h061; rta[2] = 10'h041; rta[3] = 10'h021;
        do_start(10'h020);
        for (int i = 0; i < 4; i++) begin
            call = 1; abs_target = tgt[i];
            tick();
            total++; if (PC !== tgt[i] || sp !== 3'(i + 1)) begin $display("FAIL call_%0d: got %h/%0d want %h/%0d", i, PC, sp, tgt[i], i + 1); bad++; end
        end
        abs_target = 10'h200;
        tick();
        total++; if (stack_ovf !== 1'b1 || done !== 1'b1) begin $display("FAIL call_ovf: got ovf=%b done=%b want 1/1", stack_ovf, done); bad++; end
        total++; if (PC !== 10'h100 || sp !== 3'd4) begin $display("FAIL call_ovf_hold: got %h/%0d want 100/4", PC, sp); bad++; end
        call = 0;
        do_start(10'h020);
        total++; if (stack_ovf !== 1'b0 || done !== 1'b0 || sp !== 3'd0) begin $display("FAIL restart_clear: got %b/%b/%0d want 0/0/0", stack_ovf, done, sp); bad++; end
        for (int i = 0; i < 4; i++) begin
            call = 1; abs_target = tgt[i];
            tick();
        end
        // ret and call together: ret wins.
        call = 1; ret = 1; abs_target = 10'h3C0;
        tick();
        total++; if (PC !== rta[0] || sp !== 3'd3) begin $display("FAIL ret_over_call: got %h/%0d want %h/3", PC, sp, rta[0]); bad++; end
        call = 0;
        for (int i = 1; i < 4; i++) begin
            tick();
            total++; if (PC !== rta[i] || sp !== 3'(3 - i)) begin $display("FAIL ret_%0d: got %h/%0d want %h/%0d", i, PC, sp, rta[i], 3 - i); bad++; end
        end
        total++; if (inst_ct !== 16'd8) begin $display("FAIL callret_inst_ct: got %0d want 8", inst_ct); bad++; end
        tick();
        total++; if (stack_unf !== 1'b1 || done !== 1'b1 || PC !== 10'h021) begin $display("FAIL ret_unf: got unf=%b done=%b pc=%h want 1/1/021", stack_unf, done, PC); bad++; end
        total++; if (inst_ct !== 16'd8 || stack_ovf !== 1'b0) begin $display("FAIL ret_unf_side: got %0d/%b want 8/0", inst_ct, stack_ovf); bad++; end
        clear_inputs();
    endtask

    task automatic test_stall();
        do_start(10'h030);
        stall = 1; jump_abs = 1; abs_target = 10'h1AA;
        tick(); tick();
        total++; if (PC !== 10'h030) begin $display("FAIL stall_pc: got %h want %h", PC, 10'h030); bad++; end
        total++; if (cycle_ct !== 16'd2 || inst_ct !== 16'd0) begin $display("FAIL stall_counters: got %0d/%0d want 2/0", cycle_ct, inst_ct); bad++; end
        stall = 0;
        tick();
        total++; if (PC !== 10'h1AA || cycle_ct !== 16'd3 || inst_ct !== 16'd1) begin $display("FAIL stall_release: got %h/%0d/%0d want 1aa/3/1", PC, cycle_ct, inst_ct); bad++; end
        clear_inputs();
    endtask

    task automatic test_halt();
        halt_req = 1;
        tick();
        halt_req = 0;
        total++; if (done !== 1'b1 || PC !== 10'h1AA) begin $display("FAIL halt_enter: got %b/%h want 1/1aa", done, PC); bad++; end
        total++; if (cycle_ct !== 16'd4 || inst_ct !== 16'd1) begin $display("FAIL halt_counters: got %0d/%0d want 4/1", cycle_ct, inst_ct); bad++; end
        jump_abs = 1; abs_target = 10'h2BB;
        for (int i = 0; i < 10; i++) tick();
        jump_abs = 0;
        total++; if (done !== 1'b1 || PC !== 10'h1AA || cycle_ct !== 16'd4 || inst_ct !== 16'd1) begin $display("FAIL halt_frozen: got %b/%h/%0d/%0d want 1/1aa/4/1", done, PC, cycle_ct, inst_ct); bad++; end
        do_start(10'h055);
        total++; if (done !== 1'b0 || PC !== 10'h055 || cycle_ct !== 16'd0 || inst_ct !== 16'd0) begin $display("FAIL halt_exit: got %b/%h/%0d/%0d want 0/055/0/0", done, PC, cycle_ct, inst_ct); bad++; end
    endtask

    task automatic test_async_reset();
        do_start(10'h070);
        call = 1; abs_target = 10'h150;
        tick();
        call = 0;
        total++; if (PC !== 10'h150 || sp !== 3'd1) begin $display("FAIL pre_reset: got %h/%0d want 150/1", PC, sp); bad++; end
        #2;
        reset_n = 0;
        #1;
        total++; if (PC !== 10'h000 || sp !== 3'd0 || done !== 1'b0) begin $display("FAIL async_reset: got %h/%0d/%b want 000/0/0", PC, sp, done); bad++; end
        total++; if (cycle_ct !== 16'd0 || inst_ct !== 16'd0) begin $display("FAIL async_reset_ct: got %0d/%0d want 0/0", cycle_ct, inst_ct); bad++; end
        #2;
        reset_n = 1;
        tick(); tick();
        total++; if (PC !== 10'h000 || cycle_ct !== 16'd0) begin $display("FAIL post_reset_idle: got %h/%0d want 000/0", PC, cycle_ct); bad++; end
    endtask

    task automatic test_saturation();
        do_start(10'h000);
        for (int i = 0; i < 20; i++) tick();
        total++; if (cycle_ct4 !== 4'd15 || inst_ct4 !== 4'd15) begin $display("FAIL sat_cw4: got %0d/%0d want 15/15", cycle_ct4, inst_ct4); bad++; end
        total++; if (cycle_ct !== 16'd20 || inst_ct !== 16'd20 || PC !== 10'h014) begin $display("FAIL sat_cw16: got %0d/%0d/%h want 20/20/014", cycle_ct, inst_ct, PC); bad++; end
    endtask

    initial begin
        reset_n = 0;
        clear_inputs();
        test_reset();
        test_start_run();
        test_branch();
        test_call_ret();
        test_stall();
        test_halt();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_stack_seq.md
Name: pc_stack_seq

Overview:
- Parametrised next-generation program-counter sequencer for the 9-bit-instruction accumulator core.
- Sits between Ctrl/ALU and InstROM; drives the instruction fetch address.
- Adds the following to the basic PC: run-state FSM, stall, absolute jump, call/return via a hardware return stack of depth SD, and saturating cycle/instruction counters.
- Core `done` comes from this block.

Parameters:
- PW, 10: PC / instruction-address width.
- TW, 8: relative branch offset width, two's complement, TW ≤ PW.
- SD, 4: return-stack depth, entries of PW bits, SD ≥ 1.
- CW, 16: counter width.
- RESET_PC, 0: PC value after reset_n.

Ports:
- CLK  input  1  clock, posedge only.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  synchronous init, active high; loads start_address.
- start_address  input  PW  PC load value on start.
- halt_req  input  1  halt instruction decoded (Ctrl).
- stall  input  1  hold PC this cycle.
- branch  input  1  relative-branch instruction.
- taken  input  1  branch condition true (ALU).
- offset  input  TW  signed relative offset.
- jump_abs  input  1  unconditional absolute jump.
- call  input  1  push return address, jump to abs_target.
- ret  input  1  pop return address into PC.
- abs_target  input  PW  absolute jump/call target.
- PC  output  PW  current fetch address.
- done  output  1  high in HALT.
- sp  output  $clog2(SD+1)  return-stack occupancy.
- stack_ovf  output  1  sticky: call with stack full.
- stack_unf  output  1  sticky: ret with stack empty.
- cycle_ct  output  CW  cycles spent in RUN.
- inst_ct  output  CW  instructions retired (PC advanced).

Behaviour:
- **Reset.** reset_n low (asynchronous) sets:
  - state=IDLE, PC=RESET_PC, sp=0;
  - stack_ovf=0, stack_unf=0;
  - cycle_ct=0, inst_ct=0, done=0.
  - Stack contents are don't-care.
  - This applies at any time, including mid-RUN.
- **States.**
  - IDLE: PC held, counters held.
  - RUN: executing.
  - HALT: done=1, everything held.
- **start.** start=1 in any state at a posedge:
  - PC←start_address, sp←0;
  - flags cleared, counters←0;
  - state←RUN.
  - start has priority over every other input.
- **RUN, cycle_ct.** Increments every RUN cycle, including stalls and the halting cycle; saturates at 2^CW−1.
- **RUN, PC update priority** (first match wins):
  1. halt_req: state←HALT, PC held, inst_ct unchanged.
  2. stall: PC held, all control inputs ignored.
  3. ret:
     - if sp==0: stack_unf←1, state←HALT, PC held;
     - else PC←stack[sp−1], sp←sp−1.
  4. call:
     - if sp==SD: stack_ovf←1, state←HALT, PC held, stack unchanged;
     - else stack[sp]←PC+1 (mod 2^PW), sp←sp+1, PC←abs_target.
  5. jump_abs: PC←abs_target.
  6. branch && taken: PC←PC + sign_extend(offset), modulo 2^PW (wraps both directions).
  7. Otherwise: PC←PC+1; wraps 2^PW−1→0.
- **inst_ct.** Increments (saturating) on any cycle where priority 3–7 completes without fault.
- **Control combinations.**
  - call and ret together: ret wins, call ignored.
  - branch with taken=0: PC+1.
- **Latency.** All PC updates take effect at the next posedge; PC is a registered output with no combinational path from inputs.
- **HALT exit.** Left only by start or reset_n.

Test Plan:
- **Reset then start.** reset_n low, release, start=1 with start_address=0x010 → PC=0x010, state RUN, counters 0. After 3 plain cycles: PC=0x013, cycle_ct=3, inst_ct=3.
- **Relative branch.** PC=0x005, branch=1, taken=1, offset=0xFE (−2) → PC=0x003. With taken=0 → PC=0x006. PC=0x000, offset=0xFF → PC=0x3FF (wrap). PC=0x3FF with no branch → PC=0x000.
- **Call/return nesting (SD=4).**
  - Calls from 0x020, 0x040, 0x060, 0x080 → sp=4, PC=abs_target each time.
  - 5th call → stack_ovf=1, done=1, PC held.
  - After restart: 4 nested calls then 4 rets → PCs 0x081, 0x061, 0x041, 0x021, sp=0.
  - 5th ret → stack_unf=1, done=1.
- **Stall.** stall=1 for 2 cycles with jump_abs=1 → PC unchanged, cycle_ct+2, inst_ct+0. Release with jump_abs=1, abs_target=0x1AA → PC=0x1AA.
- **Halt.** halt_req=1 → next cycle done=1, PC and counters frozen for 10 cycles. Then start=1 → RUN, done=0, counters 0.
- **Async reset mid-RUN.** reset_n asserted between clock edges → PC=RESET_PC, done=0, sp=0 immediately, without a clock edge. Saturation check with CW=4: cycle_ct holds 15 after 20 RUN cycles.
